// File: rtl/lane_gather.sv
// lane_gather: packs a stream of WIDTH-bit beats into NLANES-lane words.
// Beat k of a word lands in lane k. A finished word sits in an output
// register with valid/ready handshaking, and the output runs back-to-back
// with no bubble.
// Optional feature macro: LANE_GATHER_LAST_EN. When it is defined, in_last
// closes a word early and any unfilled lanes are zeroed. When it is not
// defined, in_last is ignored and words close only when all lanes are full.
module lane_gather #(
    parameter int NLANES = 4,
    parameter int WIDTH  = 8
) (
    input  logic                           clock,
    input  logic                           reset_n,
    input  logic [WIDTH-1:0]               in_data,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic                           in_last,
    output logic [NLANES-1:0][WIDTH-1:0]   out_data,
    output logic [NLANES-1:0]              out_mask,
    output logic                           out_valid,
    input  logic                           out_ready
);

    localparam int            CW        = $clog2(NLANES);
    localparam logic [CW-1:0] LAST_LANE = CW'(NLANES - 1);

    logic [CW-1:0]                 count;
    logic [NLANES-1:0][WIDTH-1:0]  asm_data;
    logic [NLANES-1:0]             asm_mask;
    logic [NLANES-1:0][WIDTH-1:0]  word_data;
    logic [NLANES-1:0]             word_mask;
    logic                          accept;
    logic                          last_eff;
    logic                          close_word;

    // The output register can take a new word when it is empty or is being drained.
    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

`ifdef LANE_GATHER_LAST_EN
    assign last_eff = in_last;
`else
    // in_last stays on the port but can never close a word in this build.
    assign last_eff = in_last & 1'b0;
`endif

    // A last beat on the final lane is just an ordinary full close.
    assign close_word = accept && ((count == LAST_LANE) || last_eff);

    // Assembly buffer with the incoming beat merged into its current lane.
    always_comb begin
        word_data        = asm_data;
        word_mask        = asm_mask;
        word_data[count] = in_data;
        word_mask[count] = 1'b1;
    end

    // Lane counter and partial-word buffer; both clear whenever a word closes.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count    <= '0;
            asm_data <= '0;
            asm_mask <= '0;
        end else if (accept) begin
            if (close_word) begin
                count    <= '0;
                asm_data <= '0;
                asm_mask <= '0;
            end else begin
                count    <= count + 1'b1;
                asm_data <= word_data;
                asm_mask <= word_mask;
            end
        end
    end

    // Output register: loads on close, otherwise drops valid once the word is taken.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_mask  <= '0;
        end else if (close_word) begin
            out_valid <= 1'b1;
            out_data  <= word_data;
            out_mask  <= word_mask;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_lane_gather.sv
// tb_lane_gather: self-checking bench for lane_gather with the default
// parameters (NLANES=4, WIDTH=8). Define LANE_GATHER_LAST_EN for both the
// RTL and this bench to exercise early close.
module tb_lane_gather;

    logic                  clock;
    logic                  reset_n;
    logic [7:0]            in_data;
    logic                  in_valid;
    logic                  in_ready;
    logic                  in_last;
    logic [3:0][7:0]       out_data;
    logic [3:0]            out_mask;
    logic                  out_valid;
    logic                  out_ready;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0]  data;
        logic        last;
        logic        closes;
        logic [31:0] word;
        logic [3:0]  mask;
    } vec_t;

    typedef struct {
        logic [31:0] word;
        logic [3:0]  mask;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];

    lane_gather #(.NLANES(4), .WIDTH(8)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_last   (in_last),
        .out_data  (out_data),
        .out_mask  (out_mask),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    // 10-time-unit clock.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Hard stop in case something stalls indefinitely.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    function automatic void add_vec(input logic [7:0] data, input logic last,
                                    input logic closes, input logic [31:0] word,
                                    input logic [3:0] mask);
        vec_t v;
        v.data   = data;
        v.last   = last;
        v.closes = closes;
        v.word   = word;
        v.mask   = mask;
        vecs.push_back(v);
    endfunction

    // Drive one beat that must be accepted; queue its expected word if it closes one.
    task automatic apply_stimulus(input logic [7:0] data, input logic last,
                                  input logic closes, input logic [31:0] word,
                                  input logic [3:0] mask);
        exp_t e;
        in_valid = 1'b1;
        in_data  = data;
        in_last  = last;
        #1;
        check_output("in_ready_on_beat", {31'b0, in_ready}, 32'h1);
        if (closes) begin
            e.word = word;
            e.mask = mask;
            sb.push_back(e);
        end
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = 8'h00;
    endtask

    task automatic pulse_reset();
        #1;
        reset_n = 1'b0;
        #1;
        check_output("rst_out_valid", {31'b0, out_valid}, 32'h0);
        check_output("rst_out_data", out_data, 32'h0);
        check_output("rst_out_mask", {28'b0, out_mask}, 32'h0);
        check_output("rst_in_ready", {31'b0, in_ready}, 32'h1);
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock);
        #1;
    endtask

    // Scoreboard: compare each word as it transfers against the oldest expected one.
    always @(negedge clock) begin
        if (reset_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_word: got 0x%0h mask 0x%0h expected none",
                         out_data, out_mask);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check_output("word_data", out_data, e.word);
                check_output("word_mask", {28'b0, out_mask}, {28'b0, e.mask});
            end
        end
    end

    initial begin
        reset_n   = 1'b0;
        in_data   = 8'h00;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;

        // Vector table: beats streamed back-to-back with out_ready held at 1.
        add_vec(8'h11, 1'b0, 1'b0, 32'h0, 4'h0);
        add_vec(8'h22, 1'b0, 1'b0, 32'h0, 4'h0);
        add_vec(8'h33, 1'b0, 1'b0, 32'h0, 4'h0);
        add_vec(8'h44, 1'b0, 1'b1, 32'h44332211, 4'hF);
        for (int i = 1; i <= 8; i++) begin
            logic [7:0] b;
            b = 8'(i);
            if (i == 4)      add_vec(b, 1'b0, 1'b1, 32'h04030201, 4'hF);
            else if (i == 8) add_vec(b, 1'b0, 1'b1, 32'h08070605, 4'hF);
            else             add_vec(b, 1'b0, 1'b0, 32'h0, 4'h0);
        end
`ifdef LANE_GATHER_LAST_EN
        add_vec(8'hAA, 1'b0, 1'b0, 32'h0, 4'h0);
        add_vec(8'hBB, 1'b1, 1'b1, 32'h0000BBAA, 4'h3);
        add_vec(8'hCC, 1'b0, 1'b0, 32'h0, 4'h0);
        add_vec(8'hDD, 1'b0, 1'b0, 32'h0, 4'h0);
        add_vec(8'hEE, 1'b0, 1'b0, 32'h0, 4'h0);
        add_vec(8'hFF, 1'b0, 1'b1, 32'hFFEEDDCC, 4'hF);
        add_vec(8'h01, 1'b0, 1'b0, 32'h0, 4'h0);
        add_vec(8'h02, 1'b0, 1'b0, 32'h0, 4'h0);
        add_vec(8'h03, 1'b0, 1'b0, 32'h0, 4'h0);
        add_vec(8'h04, 1'b1, 1'b1, 32'h04030201, 4'hF);
        add_vec(8'h05, 1'b1, 1'b1, 32'h00000005, 4'h1);
        add_vec(8'h06, 1'b0, 1'b0, 32'h0, 4'h0);
        add_vec(8'h07, 1'b0, 1'b0, 32'h0, 4'h0);
        add_vec(8'h08, 1'b1, 1'b1, 32'h00080706, 4'h7);
`else
        add_vec(8'hA1, 1'b1, 1'b0, 32'h0, 4'h0);
        add_vec(8'hA2, 1'b0, 1'b0, 32'h0, 4'h0);
        add_vec(8'hA3, 1'b0, 1'b0, 32'h0, 4'h0);
        add_vec(8'hA4, 1'b0, 1'b1, 32'hA4A3A2A1, 4'hF);
        add_vec(8'h5A, 1'b1, 1'b0, 32'h0, 4'h0);
        add_vec(8'h5B, 1'b1, 1'b0, 32'h0, 4'h0);
        add_vec(8'h5C, 1'b1, 1'b0, 32'h0, 4'h0);
        add_vec(8'h5D, 1'b1, 1'b1, 32'h5D5C5B5A, 4'hF);
`endif

        // Reset state.
        #1;
        check_output("reset_out_valid", {31'b0, out_valid}, 32'h0);
        check_output("reset_out_data", out_data, 32'h0);
        check_output("reset_out_mask", {28'b0, out_mask}, 32'h0);
        check_output("reset_in_ready", {31'b0, in_ready}, 32'h1);
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        check_output("post_reset_in_ready", {31'b0, in_ready}, 32'h1);

        for (int i = 0; i < vecs.size(); i++)
            apply_stimulus(vecs[i].data, vecs[i].last, vecs[i].closes,
                           vecs[i].word, vecs[i].mask);
        @(posedge clock);
        #1;

        // Backpressure: the word is held while the sink stalls, then drains in one cycle.
        out_ready = 1'b0;
        apply_stimulus(8'h10, 1'b0, 1'b0, 32'h0, 4'h0);
        apply_stimulus(8'h20, 1'b0, 1'b0, 32'h0, 4'h0);
        apply_stimulus(8'h30, 1'b0, 1'b0, 32'h0, 4'h0);
        apply_stimulus(8'h40, 1'b0, 1'b1, 32'h40302010, 4'hF);
        for (int c = 0; c < 3; c++) begin
            check_output("stall_out_valid", {31'b0, out_valid}, 32'h1);
            check_output("stall_in_ready", {31'b0, in_ready}, 32'h0);
            check_output("stall_out_data", out_data, 32'h40302010);
            check_output("stall_out_mask", {28'b0, out_mask}, 32'hF);
            @(posedge clock);
            #1;
        end
        out_ready = 1'b1;
        @(posedge clock);
        #1;
        out_ready = 1'b0;
        check_output("drain_out_valid", {31'b0, out_valid}, 32'h0);
        check_output("drain_in_ready", {31'b0, in_ready}, 32'h1);
        check_output("drain_sb_empty", sb.size(), 32'h0);
        out_ready = 1'b1;

        // Reset with a pending output word: it must never be emitted.
        out_ready = 1'b0;
        apply_stimulus(8'h71, 1'b0, 1'b0, 32'h0, 4'h0);
        apply_stimulus(8'h72, 1'b0, 1'b0, 32'h0, 4'h0);
        apply_stimulus(8'h73, 1'b0, 1'b0, 32'h0, 4'h0);
        apply_stimulus(8'h74, 1'b0, 1'b0, 32'h0, 4'h0);
        check_output("pending_out_valid", {31'b0, out_valid}, 32'h1);
        pulse_reset();
        out_ready = 1'b1;
        repeat (2) @(posedge clock);
        #1;

        // Reset with a partial word: assembly restarts from lane 0.
        apply_stimulus(8'h55, 1'b0, 1'b0, 32'h0, 4'h0);
        apply_stimulus(8'h66, 1'b0, 1'b0, 32'h0, 4'h0);
        pulse_reset();
        apply_stimulus(8'h01, 1'b0, 1'b0, 32'h0, 4'h0);
        apply_stimulus(8'h02, 1'b0, 1'b0, 32'h0, 4'h0);
        apply_stimulus(8'h03, 1'b0, 1'b0, 32'h0, 4'h0);
        apply_stimulus(8'h04, 1'b0, 1'b1, 32'h04030201, 4'hF);

        // Give outstanding words a bounded time to appear.
        for (int c = 0; c < 20 && sb.size() != 0; c++)
            @(posedge clock);
        repeat (3) @(posedge clock);
        #1;
        check_output("final_sb_empty", sb.size(), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lane_gather.md
LANE_GATHER -- requirements
Module: lane_gather

Interface
REQ-001 SHALL have parameter NLANES, default 4: number of lanes in the packed output word; legal range 2..16.
REQ-002 SHALL have parameter WIDTH, default 8: bits per lane.
REQ-003 SHALL have port clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port in_data, input, WIDTH bits: one lane element per beat.
REQ-006 SHALL have port in_valid, input, 1 bit: in_data is valid.
REQ-007 SHALL have port in_ready, output, 1 bit: block accepts a beat; a beat transfers when in_valid and in_ready are both 1.
REQ-008 SHALL have port in_last, input, 1 bit: this beat closes the current word early.
REQ-009 SHALL have port out_data, output, packed [NLANES-1:0][WIDTH-1:0]: the assembled word.
REQ-010 SHALL have port out_mask, output, NLANES bits: bit i set means lane i holds a received element.
REQ-011 SHALL have port out_valid, output, 1 bit: out_data and out_mask are valid.
REQ-012 SHALL have port out_ready, input, 1 bit: sink accepts the word; a word transfers when out_valid and out_ready are both 1.

Function
REQ-013 SHALL write the k-th accepted beat of a word into lane k, so the first beat lands in out_data[0].
REQ-014 SHALL keep a lane counter 0..NLANES-1 that increments on each accepted beat and returns to 0 when a word closes.
REQ-015 SHALL close the word on an accepted beat when the counter equals NLANES-1 or in_last=1.
REQ-016 SHALL load the closed word into the output register, set out_valid the cycle after the closing beat (latency 1), and clear the assembly buffer and counter in that same edge.
REQ-017 SHALL drive in_ready = !out_valid || out_ready; in_ready is independent of in_valid and in_last.
REQ-018 SHALL clear out_valid after a transfer unless a new word closes on the same edge; in that case it loads the new word and holds out_valid=1 (back-to-back, no bubble).
REQ-019 SHALL hold out_data and out_mask stable while out_valid=1 and out_ready=0.
REQ-020 SHALL zero unfilled lanes in a word closed early, with their out_mask bits clear.
REQ-021 SHALL sustain a throughput of one beat per cycle when out_ready is held at 1.
REQ-022 SHALL treat in_last on a beat at counter NLANES-1 as an ordinary full close, not as two closes.

Reset
REQ-023 SHALL, while reset_n=0, asynchronously clear out_valid, out_data, out_mask, the counter and the assembly buffer.
REQ-024 SHALL drive in_ready=1 during reset and after reset is released.
REQ-025 SHALL discard a partially assembled word and any pending output word when reset is asserted mid-operation; nothing is emitted for them.

Configuration
REQ-026 SHALL provide macro LANE_GATHER_LAST_EN: when defined, in_last behaves as in REQ-008, REQ-015, REQ-020 and REQ-022.
REQ-027 SHALL, when LANE_GATHER_LAST_EN is undefined, keep the in_last port but ignore it, close words only at counter NLANES-1, and drive out_mask to all-ones whenever out_valid=1.

Verification
REQ-028 SHALL cover: defaults, bytes 0x11,0x22,0x33,0x44 with out_ready=1 -> one cycle after the 4th beat, out_data=0x44332211 and out_mask=4'b1111.
REQ-029 SHALL cover: LANE_GATHER_LAST_EN defined, 0xAA then 0xBB with in_last=1 -> out_data=0x0000BBAA and out_mask=4'b0011; the next beat lands in lane 0.
REQ-030 SHALL cover: out_ready=0 with one word pending -> in_ready=0 and out_data held; raising out_ready for one cycle -> word transfers and in_ready returns to 1.
REQ-031 SHALL cover: 8 consecutive beats 0x01..0x08 with out_ready=1 -> words 0x04030201 then 0x08070605, in_ready constantly 1.
REQ-032 SHALL cover: reset_n pulsed low after 2 of 4 beats -> all outputs 0 immediately, in_ready=1; the next 4 beats 0x01..0x04 give 0x04030201.
REQ-033 SHALL cover: LANE_GATHER_LAST_EN undefined, in_last=1 on the 1st beat -> no early close; the word emits only after the 4th beat with out_mask=4'b1111.
